lane_note_scroller: RTL

Parametrised N-lane scrolling note track for the rhythm game. Each lane is a TRACK_LEN-cell shift register. Notes are NOTE_LEN-cell runs injected by an internal LFSR on spawn strobes and shifted one cell per step strobe toward a hit window. The block scores button presses against the window, counts misses, and renders per-lane pixel regions from the VGA scan position for the top-level colour mux.

---
 rtl/lane_note_scroller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/lane_note_scroller.sv
// lane_note_scroller: N-lane scrolling note track with hit scoring and pixel render.
// Ports: clk_i/rst_i (sync, active-high), en_i, step_i, spawn_i, btn_i, x_i, y_i,
//   lane_pix_o, zone_pix_o, hit_o, miss_o, bad_o, hit_cnt_o, miss_cnt_o.
module lane_note_scroller #(
  parameter int NUM_LANES  = 4,
  parameter int TRACK_LEN  = 640,
  parameter int NOTE_LEN   = 32,
  parameter int HIT_LO     = 600,
  parameter int HIT_HI     = 639,
  parameter int LANE_Y0    = 0,
  parameter int LANE_PITCH = 142,
  parameter int LANE_WIDTH = 18,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 step_i,
  input  logic                 spawn_i,
  input  logic [NUM_LANES-1:0] btn_i,
  input  logic [9:0]           x_i,
  input  logic [8:0]           y_i,
  output logic [NUM_LANES-1:0] lane_pix_o,
  output logic                 zone_pix_o,
  output logic [NUM_LANES-1:0] hit_o,
  output logic [NUM_LANES-1:0] miss_o,
  output logic [NUM_LANES-1:0] bad_o,
  output logic [15:0]          hit_cnt_o,
  output logic [15:0]          miss_cnt_o
);

  localparam int RW = $clog2(NOTE_LEN + 1);
  localparam int XW = $clog2(TRACK_LEN);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'd0) ? 16'd1 : LFSR_SEED;

  function automatic logic [TRACK_LEN-1:0] win_mask();
    logic [TRACK_LEN-1:0] m;
    m = '0;
    for (int i = HIT_LO; i <= HIT_HI; i++) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [TRACK_LEN-1:0] WIN = win_mask();

  logic [TRACK_LEN-1:0] r_track [NUM_LANES];
  logic [RW-1:0]        r_run   [NUM_LANES];
  logic [NUM_LANES-1:0] r_btn_q;
  logic [NUM_LANES-1:0] r_last;
  logic [15:0]          r_lfsr;
  logic [NUM_LANES-1:0] r_hit;
  logic [NUM_LANES-1:0] r_miss;
  logic [NUM_LANES-1:0] r_bad;
  logic [15:0]          r_hit_cnt;
  logic [15:0]          r_miss_cnt;
  logic [NUM_LANES-1:0] r_lane_pix;
  logic                 r_zone_pix;

  logic [TRACK_LEN-1:0] w_trk_c [NUM_LANES];
  logic [TRACK_LEN-1:0] w_trk_n [NUM_LANES];
  logic [RW-1:0]        w_run_n [NUM_LANES];
  logic [15:0]          w_lfsr_n;
  int                   w_sl;
  logic [NUM_LANES-1:0] w_rise;
  logic [NUM_LANES-1:0] w_hit;
  logic [NUM_LANES-1:0] w_bad;
  logic [NUM_LANES-1:0] w_out;
  logic [NUM_LANES-1:0] w_miss;
  logic [NUM_LANES-1:0] w_last_n;
  int                   w_nh;
  int                   w_nm;
  logic [16:0]          w_hsum;
  logic [16:0]          w_msum;
  logic [NUM_LANES-1:0] w_band;
  logic [NUM_LANES-1:0] w_lpix;
  logic                 w_xin;
  logic [XW-1:0]        w_xidx;

  always_comb begin
    // Galois right-shift form of x^16+x^14+x^13+x^11+1
    w_lfsr_n = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    w_sl     = int'(r_lfsr[7:0]) % NUM_LANES;
    w_rise   = btn_i & ~r_btn_q;
    w_nh     = 0;
    w_nm     = 0;
    for (int l = 0; l < NUM_LANES; l++) begin
      w_hit[l]   = w_rise[l] & (|(r_track[l] & WIN));
      w_bad[l]   = w_rise[l] & ~(|(r_track[l] & WIN));
      // a hit clears the window before the shift and miss check see it
      w_trk_c[l] = w_hit[l] ? (r_track[l] & ~WIN) : r_track[l];
      w_out[l]   = w_trk_c[l][TRACK_LEN-1];
      w_miss[l]  = step_i & w_out[l] & ~r_last[l];
      w_last_n[l] = step_i ? w_out[l] : r_last[l];
      w_trk_n[l] = step_i ? {w_trk_c[l][TRACK_LEN-2:0], r_run[l] != '0}
                          : w_trk_c[l];
      w_run_n[l] = r_run[l];
      if (step_i && r_run[l] != '0) w_run_n[l] = r_run[l] - 1'b1;
      if (spawn_i && l == w_sl && r_run[l] == '0)
        w_run_n[l] = RW'(NOTE_LEN);
      w_nh = w_nh + int'(w_hit[l]);
      w_nm = w_nm + int'(w_miss[l]);
    end
    w_hsum = {1'b0, r_hit_cnt} + 17'(w_nh);
    w_msum = {1'b0, r_miss_cnt} + 17'(w_nm);
  end

  always_comb begin
    w_xin  = int'(x_i) < TRACK_LEN;
    w_xidx = x_i[XW-1:0];
    for (int l = 0; l < NUM_LANES; l++) begin
      w_band[l] = (int'(y_i) >= LANE_Y0 + l * LANE_PITCH) &&
                  (int'(y_i) <  LANE_Y0 + l * LANE_PITCH + LANE_WIDTH);
      w_lpix[l] = w_band[l] & w_xin & r_track[l][w_xidx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        r_track[l] <= '0;
        r_run[l]   <= '0;
      end
      r_btn_q    <= '0;
      r_last     <= '0;
      r_lfsr     <= SEED;
      r_hit      <= '0;
      r_miss     <= '0;
      r_bad      <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_lane_pix <= '0;
      r_zone_pix <= 1'b0;
    end else begin
      // tracked while frozen so re-enable sees no false edge
      r_btn_q    <= btn_i;
      r_lane_pix <= w_lpix;
      r_zone_pix <= (int'(x_i) >= HIT_LO) && (int'(x_i) <= HIT_HI) &&
                    (|w_band);
      r_hit      <= en_i ? w_hit  : '0;
      r_miss     <= en_i ? w_miss : '0;
      r_bad      <= en_i ? w_bad  : '0;
      if (en_i) begin
        for (int l = 0; l < NUM_LANES; l++) begin
          r_track[l] <= w_trk_n[l];
          r_run[l]   <= w_run_n[l];
        end
        r_last     <= w_last_n;
        r_lfsr     <= w_lfsr_n;
        r_hit_cnt  <= w_hsum[16] ? 16'hFFFF : w_hsum[15:0];
        r_miss_cnt <= w_msum[16] ? 16'hFFFF : w_msum[15:0];
      end
    end
  end

  assign lane_pix_o = r_lane_pix;
  assign zone_pix_o = r_zone_pix;
  assign hit_o      = r_hit;
  assign miss_o     = r_miss;
  assign bad_o      = r_bad;
  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;

endmodule
